// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipeline: instruction/PC widths and opcode constants.
package cpu_pkg;
  localparam int IW = 16;
  localparam int AW = 16;

  localparam logic [3:0] OPC_HLT = 4'b1111;
  localparam logic [3:0] OPC_J   = 4'b1101;

  function automatic logic is_hlt(input logic [3:0] opc);
    return opc == OPC_HLT;
  endfunction
endpackage

// File: rtl/fetch_queue_mem.sv
// Storage array for the fetch queue: DEPTH x W registers, one write port, one async read port.
module fetch_queue_mem #(
  parameter int DEPTH = 2,
  parameter int W     = 32,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [PW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [PW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fetch_queue.sv
// IF->ID instruction buffer with HLT freeze and redirect flush.
// Optional same-cycle pass-through on an empty queue: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int IW    = cpu_pkg::IW,
  parameter int AW    = cpu_pkg::AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [IW-1:0]            in_instr,
  input  logic [AW-1:0]            in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [IW-1:0]            out_instr,
  output logic [AW-1:0]            out_pc,
  output logic [AW-1:0]            out_npc,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count
);
  import cpu_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_halted;

  logic             w_full;
  logic             w_empty;
  logic             w_enq;
  logic             w_byp;
  logic             w_wr;
  logic             w_deq;
  logic [IW+AW-1:0] w_rdata;
  logic [IW+AW-1:0] w_head;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign in_ready = ~w_full & ~r_halted;
  assign w_enq    = in_valid & in_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp = w_empty & w_enq & ~flush;
`else
  assign w_byp = 1'b0;
`endif

  // A bypassed entry that decode takes right away never touches storage.
  assign w_wr  = w_enq & ~(w_byp & out_ready);
  assign w_deq = ~w_empty & out_ready;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .W     (IW + AW),
    .PW    (PW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr & ~flush),
    .i_waddr (r_wr_ptr),
    .i_wdata ({in_instr, in_pc}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign w_head    = w_byp ? {in_instr, in_pc} : w_rdata;
  assign out_valid = ~w_empty | w_byp;
  assign out_instr = out_valid ? w_head[IW+AW-1:AW] : '0;
  assign out_pc    = out_valid ? w_head[AW-1:0] : '0;
  assign out_npc   = out_valid ? w_head[AW-1:0] + AW'(1) : '0;
  assign halted    = r_halted;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_halted <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_enq && is_hlt(in_instr[IW-1 -: 4])) r_halted <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed checks of fetch_queue (DEPTH=2) plus a scoreboarded random run on a DEPTH=4 instance.
module tb_fetch_queue;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_vec = 0;
  int          n_err = 0;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush, a_halted;
  logic [15:0] a_in_instr, a_in_pc, a_out_instr, a_out_pc, a_out_npc;
  logic [1:0]  a_count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush, b_halted;
  logic [15:0] b_in_instr, b_in_pc, b_out_instr, b_out_pc, b_out_npc;
  logic [2:0]  b_count;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(2), .IW(16), .AW(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_instr(a_in_instr), .in_pc(a_in_pc),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_instr(a_out_instr), .out_pc(a_out_pc),
    .out_npc(a_out_npc), .out_ready(a_out_ready), .flush(a_flush), .halted(a_halted), .count(a_count)
  );

  fetch_queue #(.DEPTH(4), .IW(16), .AW(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_instr(b_out_instr), .out_pc(b_out_pc),
    .out_npc(b_out_npc), .out_ready(b_out_ready), .flush(b_flush), .halted(b_halted), .count(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] instr, input logic [15:0] pc);
    a_in_valid = 1'b1;
    a_in_instr = instr;
    a_in_pc    = pc;
  endtask

  logic [31:0] q[$];

  initial begin
    rst_n = 1'b0;
    {a_in_valid, a_out_ready, a_flush, a_in_instr, a_in_pc} = '0;
    {b_in_valid, b_out_ready, b_flush, b_in_instr, b_in_pc} = '0;
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_count", a_count, 0);
    chk("rst_valid", a_out_valid, 0);
    chk("rst_instr", a_out_instr, 0);
    chk("rst_npc", a_out_npc, 0);
    chk("rst_ready", a_in_ready, 1);
    chk("rst_halted", a_halted, 0);

    // Test 1: single entry, one-cycle latency
    push(16'h1234, 16'h0010);
    step();
    a_in_valid = 1'b0;
    #1;
    chk("t1_valid", a_out_valid, 1);
    chk("t1_instr", a_out_instr, 16'h1234);
    chk("t1_pc", a_out_pc, 16'h0010);
    chk("t1_npc", a_out_npc, 16'h0011);
    chk("t1_count", a_count, 1);
    a_out_ready = 1'b1;
    step();
    chk("t1_drained", a_out_valid, 0);
    chk("t1_count0", a_count, 0);

    // Test 2: fill, hold, FIFO drain
    a_out_ready = 1'b0;
    push(16'h1111, 16'h0020); step();
    push(16'h2222, 16'h0021); step();
    chk("t2_full_count", a_count, 2);
    chk("t2_full_ready", a_in_ready, 0);
    push(16'h3333, 16'h0022); step();
    chk("t2_held_count", a_count, 2);
    chk("t2_head_stable", a_out_instr, 16'h1111);
    a_out_ready = 1'b1;
    #1;
    chk("t2_ready_nopath", a_in_ready, 0);
    step();
    chk("t2_count_after_pop", a_count, 1);
    chk("t2_head2", a_out_instr, 16'h2222);
    chk("t2_ready_back", a_in_ready, 1);
    step();
    chk("t2_simul_count", a_count, 1);
    chk("t2_head3", a_out_instr, 16'h3333);
    a_in_valid = 1'b0;
    step();
    chk("t2_empty", a_out_valid, 0);

    // Test 3: full + flush + push
    a_out_ready = 1'b0;
    push(16'h4444, 16'h0050); step();
    push(16'h5555, 16'h0051); step();
    chk("t3_full", a_count, 2);
    push(16'h6666, 16'h0052);
    a_flush = 1'b1;
    step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("t3_flush_count", a_count, 0);
    chk("t3_flush_valid", a_out_valid, 0);
    step();
    chk("t3_lost", a_out_valid, 0);

    // Test 4: HLT freeze, drain, flush clears
    push(16'h7777, 16'h0030); step();
    push(16'hF000, 16'h0031); step();
    chk("t4_halted", a_halted, 1);
    chk("t4_ready", a_in_ready, 0);
    chk("t4_count", a_count, 2);
    push(16'h8888, 16'h0032);
    a_out_ready = 1'b1;
    step();
    chk("t4_head_hlt", a_out_instr, 16'hF000);
    chk("t4_count1", a_count, 1);
    step();
    chk("t4_drained", a_count, 0);
    chk("t4_still_halted", a_halted, 1);
    a_in_valid = 1'b0;
    a_flush = 1'b1; step(); a_flush = 1'b0;
    chk("t4_unhalt", a_halted, 0);
    chk("t4_ready_back", a_in_ready, 1);

    // Test 5: PC wrap
    a_out_ready = 1'b0;
    push(16'h0ABC, 16'hFFFF); step();
    a_in_valid = 1'b0;
    chk("t5_pc", a_out_pc, 16'hFFFF);
    chk("t5_npc_wrap", a_out_npc, 16'h0000);
    a_out_ready = 1'b1; step();
    chk("t5_empty", a_count, 0);

    // Mid-operation reset
    a_out_ready = 1'b0;
    push(16'h9999, 16'h0060); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; a_in_valid = 1'b0;
    #1;
    chk("mrst_count", a_count, 0);
    chk("mrst_valid", a_out_valid, 0);
    chk("mrst_instr", a_out_instr, 0);
    chk("mrst_ready", a_in_ready, 1);

    // Test 6: empty-queue push with decode ready
    a_out_ready = 1'b1;
    push(16'hABCD, 16'h0040);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("t6_byp_valid", a_out_valid, 1);
    chk("t6_byp_instr", a_out_instr, 16'hABCD);
    chk("t6_byp_npc", a_out_npc, 16'h0041);
    step();
    a_in_valid = 1'b0;
    chk("t6_byp_count", a_count, 0);
    push(16'hF000, 16'h0042); step();
    a_in_valid = 1'b0;
    chk("t6_byp_hlt", a_halted, 1);
    chk("t6_byp_hlt_count", a_count, 0);
`else
    chk("t6_nobyp_valid", a_out_valid, 0);
    step();
    a_in_valid = 1'b0;
    chk("t6_nobyp_count", a_count, 1);
    chk("t6_nobyp_instr", a_out_instr, 16'hABCD);
    step();
    chk("t6_nobyp_drain", a_count, 0);
`endif
    a_flush = 1'b1; step(); a_flush = 1'b0;

    // Random push/pop on DEPTH=4 against a queue model
    for (int i = 0; i < 40; i++) begin
      logic       enq, byp;
      logic [31:0] exp_head;
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      b_in_instr  = {4'($urandom_range(0, 14)), 12'($urandom)};
      b_in_pc     = 16'($urandom);
      #1;
      enq = b_in_valid && (q.size() < 4);
      byp = BYP && (q.size() == 0) && enq;
      exp_head = (q.size() > 0) ? q[0] : {b_in_instr, b_in_pc};
      chk("rnd_ready", b_in_ready, 32'(q.size() < 4));
      chk("rnd_valid", b_out_valid, 32'((q.size() > 0) || byp));
      if ((q.size() > 0) || byp) chk("rnd_head", {b_out_instr, b_out_pc}, exp_head);
      if ((q.size() > 0) && b_out_ready) void'(q.pop_front());
      if (enq && !(byp && b_out_ready)) q.push_back({b_in_instr, b_in_pc});
      step();
      chk("rnd_count", b_count, q.size());
    end
    b_in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
